sipo_deser: RTL and testbench

Serial-in parallel-out deserializer: the receive end of the 4-bit PISO link. It samples one serial bit per enabled clock, assembles WIDTH-bit words and presents each completed word on a one-entry valid/ready output buffer. It sits directly on the PISO `so` line, with `sin_en` driven by the transmitter's shift phase (`load_shiftb` low).

---
 rtl/sipo_pkg.sv | 18 +
 rtl/sipo_shift_core.sv | 73 +++++++
 rtl/sipo_deser.sv | 74 +++++++
 tb/tb_sipo_deser.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deserializer.
// Contents: default word width, counter-width helper, output buffer state enum.
package sipo_pkg;

  localparam int unsigned SIPO_WIDTH_DEF = 4;

  // Output buffer occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  // Bits needed to count up to (and including) w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter of the SIPO deserializer.
// Samples si on every enabled edge and flags the edge that samples the last
// bit of a frame. Optional feature macro: SIPO_PARITY_EN (frame carries a
// trailing even-parity bit that is checked but not stored).
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   si, sin_en  : serial bit and its sample enable
//   clr         : frame resync, discards the partial word
//   word_c      : assembled word, valid while done_c is high
//   done_c      : this edge completes a frame
//   par_err_c   : parity result of the completing frame (0 without parity)
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = SIPO_WIDTH_DEF,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             si,
  input  logic             sin_en,
  input  logic             clr,
  output logic [WIDTH-1:0] word_c,
  output logic             done_c,
  output logic             par_err_c
);

`ifdef SIPO_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned CW = cnt_width(FRAME);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shift;
  logic             last;

  assign last     = (cnt == CW'(FRAME - 1));
  assign sr_shift = MSB_FIRST ? {sr[WIDTH-2:0], si} : {si, sr[WIDTH-1:1]};
  assign done_c   = sin_en & ~clr & last;

`ifdef SIPO_PARITY_EN
  // The final bit is parity, so the data register is already complete.
  assign word_c    = sr;
  assign par_err_c = ^{sr, si};
`else
  // The final bit is data; present the word including it.
  assign word_c    = sr_shift;
  assign par_err_c = 1'b0;
`endif

  // Counter and shifter; a completing edge rewinds both for the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      sr  <= '0;
    end else if (clr) begin
      cnt <= '0;
      sr  <= '0;
    end else if (sin_en) begin
      if (last) begin
        cnt <= '0;
        sr  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
        sr  <= sr_shift;
      end
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer with a one-entry valid/ready output
// buffer and overrun detection. Optional feature macro: SIPO_PARITY_EN
// (each frame ends in an even-parity bit; result reported on parity_err).
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   si, sin_en  : serial data bit and its sample enable
//   clr         : synchronous frame resync (buffer untouched)
//   q, q_valid  : completed word and its valid flag
//   q_ready     : consumer accept
//   overrun     : one-cycle pulse when a completed word is dropped
//   parity_err  : parity result of the word in q (0 without parity)
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = SIPO_WIDTH_DEF,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             si,
  input  logic             sin_en,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             overrun,
  output logic             parity_err
);

  logic [WIDTH-1:0] word_c;
  logic             done_c;
  logic             par_err_c;
  buf_state_e       state;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .si        (si),
    .sin_en    (sin_en),
    .clr       (clr),
    .word_c    (word_c),
    .done_c    (done_c),
    .par_err_c (par_err_c)
  );

  assign q_valid = (state == FULL);

  // Output buffer: load when free or freed this edge, otherwise drop and flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      q          <= '0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done_c) begin
        if (state == EMPTY || q_ready) begin
          q          <= word_c;
          parity_err <= par_err_c;
          state      <= FULL;
        end else begin
          overrun <= 1'b1;
        end
      end else if (state == FULL && q_ready) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: one MSB-first and one LSB-first
// instance share the stimulus; a frame-level model predicts every output.
module tb_sipo_deser;

  localparam int unsigned W = 4;
`ifdef SIPO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         si = 1'b0;
  logic         sin_en = 1'b0;
  logic         clr = 1'b0;
  logic         q_ready = 1'b0;
  logic [W-1:0] q_m, q_l;
  logic         v_m, v_l, o_m, o_l, p_m, p_l;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .si(si), .sin_en(sin_en), .clr(clr),
    .q(q_m), .q_valid(v_m), .q_ready(q_ready), .overrun(o_m), .parity_err(p_m)
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .si(si), .sin_en(sin_en), .clr(clr),
    .q(q_l), .q_valid(v_l), .q_ready(q_ready), .overrun(o_l), .parity_err(p_l)
  );

  // Frame-level model: collect received bits, build words when a frame fills.
  logic         bits[$];
  logic [W-1:0] m_qm = '0;
  logic [W-1:0] m_ql = '0;
  logic         m_v = 1'b0;
  logic         m_o = 1'b0;
  logic         m_p = 1'b0;

  always @(posedge clk) begin
    bit           cmpl;
    logic [W-1:0] wm, wl;
    logic         par;
    cmpl = 1'b0;
    wm = '0;
    wl = '0;
    par = 1'b0;
    if (!rst_n) begin
      bits.delete();
      m_qm = '0; m_ql = '0; m_v = 1'b0; m_o = 1'b0; m_p = 1'b0;
    end else begin
      m_o = 1'b0;
      if (clr) begin
        bits.delete();
      end else if (sin_en) begin
        bits.push_back(si);
        if (bits.size() == FRAME) begin
          cmpl = 1'b1;
          for (int i = 0; i < int'(W); i++) begin
            wm[W-1-i] = bits[i];
            wl[i]     = bits[i];
          end
          for (int i = 0; i < FRAME; i++) par = par ^ bits[i];
          bits.delete();
        end
      end
      if (cmpl) begin
        if (!m_v || q_ready) begin
          m_qm = wm; m_ql = wl; m_v = 1'b1;
`ifdef SIPO_PARITY_EN
          m_p = par;
`else
          m_p = 1'b0;
`endif
        end else begin
          m_o = 1'b1;
        end
      end else if (m_v && q_ready) begin
        m_v = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_q_msb", 32'(q_m), 32'(m_qm));
      chk("cyc_q_lsb", 32'(q_l), 32'(m_ql));
      chk("cyc_valid_msb", 32'(v_m), 32'(m_v));
      chk("cyc_valid_lsb", 32'(v_l), 32'(m_v));
      chk("cyc_overrun_msb", 32'(o_m), 32'(m_o));
      chk("cyc_overrun_lsb", 32'(o_l), 32'(m_o));
      chk("cyc_perr_msb", 32'(p_m), 32'(m_p));
      chk("cyc_perr_lsb", 32'(p_l), 32'(m_p));
    end
  end

  task automatic step(input logic s, input logic e, input logic c, input logic r);
    si = s; sin_en = e; clr = c; q_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Sends w first-bit-first (w[W-1] first), plus parity when enabled.
  // q_ready is raised only on the completing bit when rdy_last is set.
  task automatic send_frame(input logic [W-1:0] w, input logic bad_par,
                            input logic rdy_last, input int gap);
    for (int i = int'(W) - 1; i >= 0; i--) begin
      logic r;
      r = 1'b0;
`ifndef SIPO_PARITY_EN
      if (i == 0) r = rdy_last;
`endif
      step(w[i], 1'b1, 1'b0, r);
      if (i > 0) repeat (gap) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
`ifdef SIPO_PARITY_EN
    step((^w) ^ bad_par, 1'b1, 1'b0, rdy_last);
`else
    if (bad_par) step(1'b0, 1'b0, 1'b0, 1'b0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_q", 32'(q_m), 32'h0);
    chk("rst_valid", 32'(v_m), 32'h0);
    chk("rst_overrun", 32'(o_m), 32'h0);
    chk("rst_perr", 32'(p_m), 32'h0);
    rst_n = 1'b1;

    // First word, nobody consuming.
    send_frame(4'b1011, 1'b0, 1'b0, 0);
    chk("t1_q_msb", 32'(q_m), 32'hB);
    chk("t1_q_lsb", 32'(q_l), 32'hD);
    chk("t1_valid", 32'(v_m), 32'h1);
    chk("t1_perr", 32'(p_m), 32'h0);

    // Back-to-back frame, accept on the completing edge replaces q.
    send_frame(4'b0100, 1'b0, 1'b1, 0);
    chk("t3_q_msb", 32'(q_m), 32'h4);
    chk("t3_q_lsb", 32'(q_l), 32'h2);
    chk("t3_valid", 32'(v_m), 32'h1);
    chk("t3_overrun", 32'(o_m), 32'h0);

    // Completion while full and not ready drops the word.
    send_frame(4'b1001, 1'b0, 1'b0, 0);
    chk("t4_overrun", 32'(o_m), 32'h1);
    chk("t4_q_kept", 32'(q_m), 32'h4);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_overrun_pulse", 32'(o_m), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_accept", 32'(v_m), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Gaps in sin_en hold state.
    send_frame(4'b1110, 1'b0, 1'b0, 2);
    chk("gap_q_msb", 32'(q_m), 32'hE);
    chk("gap_q_lsb", 32'(q_l), 32'h7);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // clr after two bits; the enabled bit on the clr edge is ignored.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b0, 0);
    chk("clr_q_msb", 32'(q_m), 32'h6);
    chk("clr_q_lsb", 32'(q_l), 32'h6);

    // Reset mid-frame while holding a word.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rstmid_valid", 32'(v_m), 32'h0);
    chk("rstmid_q", 32'(q_m), 32'h0);
    rst_n = 1'b1;
    send_frame(4'b0110, 1'b0, 1'b0, 0);
    chk("rstmid_q_after", 32'(q_m), 32'h6);
    chk("rstmid_valid_after", 32'(v_m), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
    send_frame(4'b1011, 1'b0, 1'b0, 0);
    chk("par_good", 32'(p_m), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(4'b1011, 1'b1, 1'b0, 0);
    chk("par_bad", 32'(p_m), 32'h1);
    chk("par_bad_q", 32'(q_m), 32'hB);
`else
    send_frame(4'b1011, 1'b1, 1'b0, 0);
    chk("par_tied", 32'(p_m), 32'h0);
`endif

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
